// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: drives an arbiter-PUF challenge/launch sequence N_EVAL times
// and reports a majority-voted response, the count of ones, and a stability flag.
module puf_eval_ctrl #(
  parameter int N_STAGES      = 64,
  parameter int SETTLE_CYCLES = 4,
  parameter int RACE_CYCLES   = 4,
  parameter int N_EVAL        = 7,
  parameter int CNT_W         = $clog2(N_EVAL + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_STAGES-1:0] challenge_in,
  input  logic                puf_resp,
  output logic [N_STAGES-1:0] puf_challenge,
  output logic                puf_launch,
  output logic                busy,
  output logic                done,
  output logic                response,
  output logic [CNT_W-1:0]    ones_count,
  output logic                stable
);
  localparam int TMAX = SETTLE_CYCLES > RACE_CYCLES ? SETTLE_CYCLES : RACE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RACE, SAMPLE, CLEAR, RESULT} state_t;

  state_t           state, next;
  logic [TW-1:0]    tcnt;
  logic [CNT_W-1:0] eval_cnt, ones_acc;
  logic [1:0]       resp_sync;

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? LOAD : IDLE;
      LOAD:    next = (tcnt == TW'(SETTLE_CYCLES - 1)) ? RACE : LOAD;
      RACE:    next = (tcnt == TW'(RACE_CYCLES - 1)) ? SAMPLE : RACE;
      SAMPLE:  next = CLEAR;
      CLEAR:   next = (tcnt != TW'(RACE_CYCLES - 1)) ? CLEAR :
                      (eval_cnt == CNT_W'(N_EVAL)) ? RESULT : RACE;
      RESULT:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so launch/busy/done line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tcnt          <= '0;
      eval_cnt      <= '0;
      ones_acc      <= '0;
      resp_sync     <= '0;
      puf_challenge <= '0;
      puf_launch    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      response      <= 1'b0;
      ones_count    <= '0;
      stable        <= 1'b0;
    end else begin
      state      <= next;
      resp_sync  <= {resp_sync[0], puf_resp};
      tcnt       <= (next != state || state == IDLE) ? '0 : tcnt + 1'b1;
      puf_launch <= next == RACE || next == SAMPLE;
      busy       <= next != IDLE;
      done       <= next == RESULT;
      if (state == IDLE && start) begin
        puf_challenge <= challenge_in;
        eval_cnt      <= '0;
        ones_acc      <= '0;
      end
      if (state == SAMPLE) begin
        ones_acc <= ones_acc + CNT_W'(resp_sync[1]);
        eval_cnt <= eval_cnt + 1'b1;
      end
      if (next == RESULT) begin
        response   <= ones_acc > CNT_W'(N_EVAL / 2);
        ones_count <= ones_acc;
        stable     <= ones_acc == '0 || ones_acc == CNT_W'(N_EVAL);
      end
    end
  end
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: randomized and directed runs of puf_eval_ctrl against a
// majority-vote model derived from the per-evaluation response pattern.
module tb_puf_eval_ctrl;
  localparam int NS = 64, S = 4, R = 4, N = 7, CW = $clog2(N + 1);
  localparam int T_DONE = S + N * (2 * R + 1);

  logic          clk = 0, rst_n = 0, start = 0, puf_resp = 0;
  logic [NS-1:0] challenge_in = '0, puf_challenge;
  logic          puf_launch, busy, done, response, stable;
  logic [CW-1:0] ones_count;
  int            tests = 0, fails = 0;
  logic          exp_resp, exp_stable;
  int            exp_ones;

  puf_eval_ctrl #(.N_STAGES(NS), .SETTLE_CYCLES(S), .RACE_CYCLES(R), .N_EVAL(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge_in(challenge_in),
    .puf_resp(puf_resp), .puf_challenge(puf_challenge), .puf_launch(puf_launch),
    .busy(busy), .done(done), .response(response), .ones_count(ones_count), .stable(stable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, "_resp"}, response, exp_resp);
    check({tag, "_ones"}, ones_count, exp_ones);
    check({tag, "_stable"}, stable, exp_stable);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_launch"}, puf_launch, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_resp"}, response, 0);
    check({tag, "_ones"}, ones_count, 0);
    check({tag, "_stable"}, stable, 0);
    check({tag, "_chal"}, puf_challenge, 0);
  endtask

  // pat[k] is the arbiter decision presented during evaluation k (bit 0 = eval 1).
  task automatic run(input logic [NS-1:0] ch, input logic [N-1:0] pat, input bit collide, input bit scramble);
    int k, rise_i, fall_i, done_i, i;
    logic pl;
    exp_ones   = $countones(pat);
    exp_resp   = exp_ones > N / 2;
    exp_stable = exp_ones == 0 || exp_ones == N;
    @(negedge clk);
    challenge_in = ch;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    check("busy_t0", busy, 1);
    k = 0; rise_i = 0; fall_i = 0; done_i = -1; pl = 0; i = 0;
    while (done_i < 0 && i < T_DONE + 20) begin
      @(posedge clk);
      #1 i++;
      if (scramble) challenge_in = {$urandom, $urandom};
      if (collide) begin
        if (i == 19) begin start = 1; challenge_in = 64'h1; end
        if (i == 20) start = 0;
      end
      check("chal_hold", puf_challenge, ch);
      check("busy_run", busy, 1);
      if (puf_launch && !pl) begin
        if (k == 0) check("first_rise", i, S);
        else check("low_width", i - fall_i, R);
        rise_i = i;
        if (k < N) puf_resp = pat[k];
        k++;
      end
      if (!puf_launch && pl) begin
        check("high_width", i - rise_i, R + 1);
        fall_i = i;
      end
      pl = puf_launch;
      if (done) done_i = i;
    end
    if (done_i < 0) check("done_timeout", 0, 1);
    check("done_at", done_i, T_DONE);
    check("pulses", k, N);
    check_results("res");
    if (collide) begin start = 1; challenge_in = 64'h1; end
    @(posedge clk);
    #1 check("done_once", done, 0);
    check("busy_end", busy, 0);
    check("chal_after", puf_challenge, ch);
    if (!collide) begin
      repeat (3) @(posedge clk);
      #1 check_results("hold");
    end
  endtask

  initial begin
    start = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 check_zero("rst");
    end
    @(negedge clk);
    rst_n = 1;
    start = 0;
    @(posedge clk);
    #1 check_zero("idle");

    run(64'hA5A5_0000_FFFF_1234, 7'h7F, 0, 0);
    run({$urandom, $urandom}, 7'b0110101, 0, 0);
    run({$urandom, $urandom}, 7'b1001010, 0, 0);

    // Collision run; the start held after the done cycle is accepted, then aborted by reset.
    run(64'hDEAD_BEEF_0BAD_F00D, 7'h7F, 1, 0);
    @(posedge clk);
    #1 start = 0;
    check("accept_after", busy, 1);
    check("accept_chal", puf_challenge, 64'h1);
    repeat (24) @(posedge clk);
    #1 check("abort_in_race", puf_launch, 1);
    rst_n = 0;
    #1 check_zero("abort");
    repeat (3) begin
      @(posedge clk);
      #1 check("abort_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1;

    run({$urandom, $urandom}, 7'($urandom), 0, 0);
    run({$urandom, $urandom}, 7'($urandom), 0, 1);
    for (int r = 0; r < 6; r++) run({$urandom, $urandom}, 7'($urandom), 0, r[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Sequencing controller for the arbiter-PUF delay chain built from the two-mux switch elements. It latches a challenge onto the chain's select lines, waits for the selects to settle, and fires the race edge into both chain inputs. It then samples the arbiter latch through a synchronizer and returns the chain to zero. The evaluation repeats N_EVAL times and the block reports a majority-voted response bit plus a stability flag to the lab host logic.

## Interface
Parameters:
- N_STAGES, 64, number of switch stages; width of the challenge.
- SETTLE_CYCLES, 4, cycles between challenge application and the first launch; minimum 1.
- RACE_CYCLES, 4, cycles the launch is held high before sampling, and cycles it is held low after; minimum 3.
- N_EVAL, 7, evaluations per challenge; odd, 1..255.
- CNT_W, $clog2(N_EVAL+1), width of ones_count.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- challenge_in  in  N_STAGES  challenge; captured on the edge that accepts start.
- puf_resp  in  1  arbiter latch output; asynchronous to clk.
- puf_challenge  out  N_STAGES  registered select lines to the switch stages.
- puf_launch  out  1  registered race edge, driven to both chain inputs.
- busy  out  1  high from the accepting edge through the RESULT cycle.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle.
- response  out  1  majority-voted response bit.
- ones_count  out  CNT_W  number of evaluations that sampled 1.
- stable  out  1  all N_EVAL evaluations agreed.

## Operation
- Reset: every output is 0, the FSM is in IDLE, counters are 0, and both synchronizer flops are 0. The asynchronous assert takes effect mid-cycle, and puf_launch drops immediately.
- Synchronizer: puf_resp feeds two flops, resp_sync. There is no other path from puf_resp.
- States:
  - IDLE: busy=0. If start=1, capture challenge_in into puf_challenge, clear eval_cnt, ones_acc and the settle/race counter, then go to LOAD.
  - LOAD: launch=0, held for SETTLE_CYCLES cycles, then go to RACE.
  - RACE: launch=1, held for RACE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: launch=1 for 1 cycle. Update ones_acc += resp_sync and eval_cnt += 1, then go to CLEAR.
  - CLEAR: launch=0, held for RACE_CYCLES cycles. Then go to RESULT if eval_cnt==N_EVAL, otherwise back to RACE.
  - RESULT: done=1 for 1 cycle, then go to IDLE. Update the result registers:
    - response = (ones_acc > N_EVAL/2).
    - ones_count = ones_acc.
    - stable = (ones_acc==0 || ones_acc==N_EVAL).
- puf_challenge holds its captured value from acceptance until the next accepted start, including after done.
- response, ones_count and stable hold until the next RESULT or reset.
- start while busy is ignored: no capture and no restart. start asserted during RESULT is also ignored; it must be present in IDLE.
- ones_acc never exceeds N_EVAL; CNT_W bits are sufficient and there is no wrap.
- Reset mid-operation: the run is aborted, no done is produced, and the result registers clear to 0.

## Timing
- Let start be sampled at edge t0.
- busy=1 from t0.
- First launch rise is at edge t0+SETTLE_CYCLES.
- Each evaluation takes 2*RACE_CYCLES+1 cycles: launch high for RACE_CYCLES+1 cycles, then low for RACE_CYCLES cycles.
- done is high in the cycle starting at edge t0+SETTLE_CYCLES+N_EVAL*(2*RACE_CYCLES+1). With defaults this is t0+67.
- busy falls at the edge ending the done cycle.
- The earliest next start is sampled one edge later.
- resp_sync reflects puf_resp 2 edges after it settles. RACE_CYCLES>=3 therefore guarantees a sample at least one cycle after full synchronization of an arbiter decision made within the first race cycle.

## Test plan
- Reset: hold rst_n=0 with start=1 for 5 cycles. All outputs stay 0 and no launch toggles. Release: IDLE, busy=0.
- Constant 1: defaults, challenge 64'hA5A5_0000_FFFF_1234, model resp=1. puf_challenge equals the challenge from t0+1. Exactly 7 launch pulses, each 5 cycles high and 4 low. done at t0+67, response=1, ones_count=7, stable=1.
- Noisy majority: model returns 1 on evals 1,3,5,6, giving response=1, ones_count=4, stable=0. Rerun with 1 on evals 2,4,7, giving response=0, ones_count=3, stable=0.
- Busy collision: second start with challenge 64'h1 at t0+20 and again on the done cycle. puf_challenge is unchanged and exactly one done pulse occurs. A start on the cycle after done is accepted.
- Abort: assert rst_n=0 during RACE of eval 3. puf_launch drops before the next edge and all outputs go to 0 with no done. After release, a new start completes normally at +67.
- Hold: change challenge_in every cycle after t0. puf_challenge stays constant through and after done; the results persist until the next RESULT.
